amns_load_unit: RTL

- Load stage of the AMNS modular-multiplication datapath, directly upstream of the FIOS core.
- Started by the top controller's load_start pulse; reports completion back on its load_done input.
- Accepts operand A and operand B coefficients from a valid/ready input stream, narrower than one coefficient.
- Assembles each coefficient from several beats and writes it into the FIOS operand memory, one write per coefficient.

---
 rtl/amns_pkg.sv | 23 ++
 rtl/amns_load_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/amns_pkg.sv
// Shared definitions for the AMNS load, FIOS and store stages.
package amns_pkg;

  localparam int AMNS_N_COEF     = 5;
  localparam int AMNS_COEF_WIDTH = 64;
  localparam int AMNS_IN_WIDTH   = 32;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_RECV  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } load_state_e;

  // Index width that stays legal for a single-entry memory.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/amns_load_unit.sv
// AMNS load stage: assembles A then B coefficients from a narrow beat stream
// and writes each one into the FIOS operand memory.
//
// state    | meaning
// ---------+---------------------------------------------------------
// LD_IDLE  | waiting for start_i
// LD_RECV  | accepting beats of the current coefficient
// LD_WRITE | one-cycle write of the assembled coefficient
// LD_DONE  | one-cycle completion pulse
module amns_load_unit
  import amns_pkg::*;
#(
  parameter  int N_COEF     = AMNS_N_COEF,
  parameter  int COEF_WIDTH = AMNS_COEF_WIDTH,
  parameter  int IN_WIDTH   = AMNS_IN_WIDTH,
  localparam int BEATS      = COEF_WIDTH / IN_WIDTH,
  localparam int ADDR_WIDTH = addr_width(N_COEF)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [IN_WIDTH-1:0]   s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic                  wr_en_o,
  output logic                  wr_sel_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [COEF_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  done_o
);

  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  load_state_e           state;
  logic [BEAT_CW-1:0]    beat_cnt;
  logic [ADDR_WIDTH-1:0] coef_cnt;
  logic                  sel;
  logic [COEF_WIDTH-1:0] asm_q;
  logic                  err_q;

  logic last_beat;
  logic last_coef;
  logic final_beat;

  assign last_beat  = (beat_cnt == BEAT_CW'(BEATS - 1));
  assign last_coef  = (coef_cnt == ADDR_WIDTH'(N_COEF - 1));
  assign final_beat = (sel == SEL_B) && last_coef && last_beat;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state    <= LD_IDLE;
      beat_cnt <= '0;
      coef_cnt <= '0;
      sel      <= SEL_A;
      asm_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (start_i) begin
            beat_cnt <= '0;
            coef_cnt <= '0;
            sel      <= SEL_A;
            err_q    <= 1'b0;
            state    <= LD_RECV;
          end
        end
        LD_RECV: begin
          if (s_valid_i) begin
            for (int b = 0; b < BEATS; b++) begin
              if (beat_cnt == BEAT_CW'(b)) asm_q[b*IN_WIDTH +: IN_WIDTH] <= s_data_i;
            end
            // Framing is informational only; the transfer always runs to completion.
            if (s_last_i != final_beat) err_q <= 1'b1;
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= LD_WRITE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        LD_WRITE: begin
          if (last_coef && (sel == SEL_B)) begin
            state <= LD_DONE;
          end else if (last_coef) begin
            sel      <= SEL_B;
            coef_cnt <= '0;
            state    <= LD_RECV;
          end else begin
            coef_cnt <= coef_cnt + 1'b1;
            state    <= LD_RECV;
          end
        end
        LD_DONE: state <= LD_IDLE;
        default: state <= LD_IDLE;
      endcase
    end
  end

  assign s_ready_o = (state == LD_RECV);
  assign wr_en_o   = (state == LD_WRITE);
  assign done_o    = (state == LD_DONE);
  assign busy_o    = (state != LD_IDLE);
  assign wr_sel_o  = sel;
  assign wr_addr_o = coef_cnt;
  assign wr_data_o = asm_q;
  assign err_o     = err_q;

endmodule
